// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer and the SrcOut writeback mux decoder.
package muldiv_pkg;
   localparam logic       OP_MULT   = 1'b0;
   localparam logic       OP_DIV    = 1'b1;
   localparam logic [1:0] MF_NONE   = 2'b00;
   localparam logic [1:0] MF_LO     = 2'b01;
   localparam logic [1:0] MF_HI     = 2'b10;
   localparam logic [2:0] SRCOUT_LO = 3'b000;
   localparam logic [2:0] SRCOUT_HI = 3'b001;

   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;
endpackage

// File: rtl/muldiv_seq_if.sv
// Control-side bundle of the multiply/divide sequencer: request, Hi/Lo results and SrcOut select.
interface muldiv_seq_if #(parameter int WIDTH = 32);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       mf_sel;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [2:0]       src_out;
   logic             src_valid;
   logic             stall;

   modport master (output start, op, a, b, mf_sel,
                   input  hi, lo, busy, done, div_zero, src_out, src_valid, stall);
   modport slave  (input  start, op, a, b, mf_sel,
                   output hi, lo, busy, done, div_zero, src_out, src_valid, stall);
endinterface

// File: rtl/muldiv_iter.sv
// Unsigned datapath: one shift-add multiply step or one restoring-divide step per i_step.
// Accumulator upper half ends as product-high / remainder, lower half as product-low / quotient.
module muldiv_iter
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               i_load,
   input  logic               i_step,
   input  logic               i_op,
   input  logic [WIDTH-1:0]   i_opa,
   input  logic [WIDTH-1:0]   i_opb,
   output logic [2*WIDTH-1:0] o_acc_nxt
);
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opb;
   logic               r_op;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_trial;
   logic [2*WIDTH-1:0] w_acc_nxt;

   always_comb begin
      w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
      w_trial   = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opb};
      w_acc_nxt = r_acc;
      if (r_op == OP_MULT) begin
         // carry out of the add is shifted into the top bit
         if (r_acc[0]) w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
         else          w_acc_nxt = {1'b0, r_acc[2*WIDTH-1:1]};
      end else begin
         if (!w_trial[WIDTH]) w_acc_nxt = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
         else                 w_acc_nxt = {r_acc[2*WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc <= '0;
         r_opb <= '0;
         r_op  <= OP_MULT;
      end else if (i_load) begin
         r_acc <= {{WIDTH{1'b0}}, i_opa};
         r_opb <= i_opb;
         r_op  <= i_op;
      end else if (i_step) begin
         r_acc <= w_acc_nxt;
      end
   end

   assign o_acc_nxt = w_acc_nxt;
endmodule

// File: rtl/muldiv_seq.sv
// Iterative signed mult/div sequencer owning Hi/Lo; sign fix-up and atomic commit live here,
// the unsigned iteration lives in muldiv_iter.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   muldiv_seq_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   state_e             r_state;
   logic [CW-1:0]      r_cnt;
   logic               r_op, r_neg_q, r_neg_r, r_dz;
   logic [WIDTH-1:0]   r_hi, r_lo;
   logic               r_busy, r_done, r_div_zero;
   logic               w_load, w_step, w_last, w_mf;
   logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_q, w_r;
   logic [2*WIDTH-1:0] w_acc_nxt, w_res;

   assign w_load  = (r_state == IDLE) && bus.start;
   assign w_step  = (r_state == MULT) || ((r_state == DIV) && !r_dz);
   assign w_last  = (r_cnt == CW'(WIDTH-1));
   assign w_abs_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
   assign w_abs_b = bus.b[WIDTH-1] ? -bus.b : bus.b;

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_load    (w_load),
      .i_step    (w_step),
      .i_op      (bus.op),
      .i_opa     (w_abs_a),
      .i_opb     (w_abs_b),
      .o_acc_nxt (w_acc_nxt)
   );

   assign w_q = w_acc_nxt[WIDTH-1:0];
   assign w_r = w_acc_nxt[2*WIDTH-1:WIDTH];

   always_comb begin
      if (r_op == OP_MULT) w_res = r_neg_q ? -w_acc_nxt : w_acc_nxt;
      else                 w_res = {r_neg_r ? -w_r : w_r, r_neg_q ? -w_q : w_q};
   end

   // Divide-by-zero passes through DIV for one cycle so done lands two cycles after start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_op       <= OP_MULT;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_dz       <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         case (r_state)
            IDLE: if (bus.start) begin
               r_op    <= bus.op;
               r_neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
               r_neg_r <= bus.a[WIDTH-1];
               r_dz    <= (bus.op == OP_DIV) && (bus.b == '0);
               r_cnt   <= '0;
               r_busy  <= 1'b1;
               r_state <= (bus.op == OP_DIV) ? DIV : MULT;
            end
            MULT, DIV: begin
               if (r_dz) begin
                  r_state    <= DONE;
                  r_done     <= 1'b1;
                  r_div_zero <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last) begin
                     r_hi    <= w_res[2*WIDTH-1:WIDTH];
                     r_lo    <= w_res[WIDTH-1:0];
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_mf          = (bus.mf_sel == MF_LO) || (bus.mf_sel == MF_HI);
   assign bus.hi        = r_hi;
   assign bus.lo        = r_lo;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.div_zero  = r_div_zero;
   assign bus.src_out   = (bus.mf_sel == MF_HI) ? SRCOUT_HI : SRCOUT_LO;
   assign bus.src_valid = w_mf && !r_busy;
   assign bus.stall     = w_mf && r_busy;
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed table, corner-case sequences and random ops against a longint model.
module tb_muldiv_seq;
   logic clk = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [31:0] m_hi = '0, m_lo = '0;

   always #5 clk = ~clk;

   muldiv_seq_if #(.WIDTH(32)) bus();
   muldiv_seq #(.WIDTH(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

   typedef struct {
      logic        op;
      logic [31:0] a, b;
      logic [31:0] exp_hi, exp_lo;
      logic        exp_dz;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        output logic [31:0] eh, output logic [31:0] el, output logic edz);
      longint sa, sb, p, q, r;
      sa  = longint'($signed(a_i));
      sb  = longint'($signed(b_i));
      edz = 1'b0;
      if (op_i == 1'b0) begin
         p = sa * sb; eh = p[63:32]; el = p[31:0];
      end else if (b_i == 32'd0) begin
         eh = m_hi; el = m_lo; edz = 1'b1;
      end else begin
         q = sa / sb; r = sa % sb; eh = r[31:0]; el = q[31:0];
      end
   endtask

   task automatic run_op(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                         input int restart_at, input int reset_at,
                         output logic [31:0] g_hi, output logic [31:0] g_lo, output logic g_dz);
      logic [31:0] eh, el;
      logic edz, mfv, bad_busy, bad_ctl, bad_hold, exp_busy;
      int elat, lat, ndone;
      model(op_i, a_i, b_i, eh, el, edz);
      elat = edz ? 2 : 33;
      mfv  = (bus.mf_sel == 2'b01) || (bus.mf_sel == 2'b10);
      g_hi = '0; g_lo = '0; g_dz = 1'b0;
      lat = 0; ndone = 0; bad_busy = 0; bad_ctl = 0; bad_hold = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.op = op_i; bus.a = a_i; bus.b = b_i;
      #1;
      chk("idle_src_valid", {63'd0, bus.src_valid}, {63'd0, mfv});
      chk("idle_hi_visible", {32'd0, bus.hi}, {32'd0, m_hi});
      for (int n = 1; n < 60; n++) begin
         @(negedge clk);
         if (n == restart_at) begin
            bus.start = 1'b1; bus.op = ~op_i; bus.a = 32'd5; bus.b = 32'd3;
         end else begin
            bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
         end
         if (n == reset_at) begin
            reset_n = 1'b0;
            #1;
            chk("rst_busy", {63'd0, bus.busy}, 64'd0);
            chk("rst_hi", {32'd0, bus.hi}, 64'd0);
            chk("rst_lo", {32'd0, bus.lo}, 64'd0);
            m_hi = '0; m_lo = '0;
            @(negedge clk);
            reset_n = 1'b1;
            bus.start = 1'b0;
            return;
         end
         exp_busy = (n <= elat);
         if (bus.busy !== exp_busy) bad_busy = 1'b1;
         if (bus.stall !== (mfv && exp_busy) || bus.src_valid !== (mfv && !exp_busy) ||
             bus.src_out !== ((bus.mf_sel == 2'b10) ? 3'b001 : 3'b000)) bad_ctl = 1'b1;
         if (n < elat && (bus.hi !== m_hi || bus.lo !== m_lo)) bad_hold = 1'b1;
         if (bus.done) begin
            ndone++;
            if (lat == 0) begin
               lat = n; g_hi = bus.hi; g_lo = bus.lo; g_dz = bus.div_zero;
            end
         end
      end
      chk("latency", 64'(lat), 64'(elat));
      chk("done_count", 64'(ndone), 64'd1);
      chk("busy_profile", {63'd0, bad_busy}, 64'd0);
      chk("stall_src_profile", {63'd0, bad_ctl}, 64'd0);
      chk("no_partial_commit", {63'd0, bad_hold}, 64'd0);
      chk("hi", {32'd0, g_hi}, {32'd0, eh});
      chk("lo", {32'd0, g_lo}, {32'd0, el});
      chk("div_zero", {63'd0, g_dz}, {63'd0, edz});
      m_hi = eh; m_lo = el;
   endtask

   initial begin
      vec_t vecs[8];
      logic [31:0] gh, gl;
      logic gdz, rop;
      logic [31:0] ra, rb;

      vecs[0] = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[2] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[3] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      vecs[4] = '{1'b1, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
      vecs[5] = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
      vecs[7] = '{1'b1, 32'd5,        32'd0,        32'h00000000, 32'h00000001, 1'b1};

      reset_n = 1'b0;
      bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0; bus.mf_sel = 2'b00;
      repeat (3) @(negedge clk);
      chk("reset_hi", {32'd0, bus.hi}, 64'd0);
      chk("reset_lo", {32'd0, bus.lo}, 64'd0);
      chk("reset_busy", {63'd0, bus.busy}, 64'd0);
      chk("reset_done", {63'd0, bus.done}, 64'd0);
      chk("reset_div_zero", {63'd0, bus.div_zero}, 64'd0);
      reset_n = 1'b1;

      // directed table against hand-computed constants
      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, gh, gl, gdz);
         chk("tbl_hi", {32'd0, gh}, {32'd0, vecs[i].exp_hi});
         chk("tbl_lo", {32'd0, gl}, {32'd0, vecs[i].exp_lo});
         chk("tbl_dz", {63'd0, gdz}, {63'd0, vecs[i].exp_dz});
      end

      // mfhi during a multiply: stall while busy, then src_out=001 valid
      bus.mf_sel = 2'b10;
      run_op(1'b0, 32'd12345, 32'hFFFF0000, 0, 0, gh, gl, gdz);
      @(negedge clk);
      chk("mfhi_src_out", {61'd0, bus.src_out}, 64'd1);
      chk("mfhi_src_valid", {63'd0, bus.src_valid}, 64'd1);
      bus.mf_sel = 2'b01;
      #1;
      chk("mflo_src_out", {61'd0, bus.src_out}, 64'd0);
      bus.mf_sel = 2'b11;
      #1;
      chk("reserved_src_valid", {63'd0, bus.src_valid}, 64'd0);
      bus.mf_sel = 2'b00;

      // second start mid-multiply is ignored
      run_op(1'b0, 32'hFFFFFF85, 32'd1000, 10, 0, gh, gl, gdz);

      // async reset mid-divide, then div-by-zero after reset keeps 0/0
      run_op(1'b1, 32'd100, 32'd7, 0, 15, gh, gl, gdz);
      run_op(1'b1, 32'd5, 32'd0, 0, 0, gh, gl, gdz);
      chk("dz_after_reset_hi", {32'd0, gh}, 64'd0);
      run_op(1'b1, 32'd100, 32'd7, 0, 0, gh, gl, gdz);

      for (int i = 0; i < 40; i++) begin
         rop = 1'($urandom_range(0, 1));
         ra  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 31);
         bus.mf_sel = 2'($urandom_range(0, 3));
         run_op(rop, ra, rb, 0, 0, gh, gl, gdz);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
